// File: rtl/instruction_fetch_unit.sv
// RV64I fetch stage: owns the PC, issues in-order word reads to instruction memory,
// buffers returned words and presents {pc, instr} to decode over valid/ready.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [63:0] id_pc,
  output logic [31:0] id_instr
);

  // state | meaning
  // RUN   | normal fetch; requests issued while credit is available
  // FLUSH | after a redirect, discarding stale responses until drop reaches 0

  localparam int            AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int            CW       = $clog2(FIFO_DEPTH + 1);
  localparam int            CW1      = CW + 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(FIFO_DEPTH - 1);
  localparam logic [CW:0]   DEPTH_C  = CW1'(FIFO_DEPTH);
  localparam logic [CW-1:0] FULL_C   = CW'(FIFO_DEPTH);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t        state, state_n;
  logic [63:0]   pc;
  logic [CW-1:0] outstanding, outstanding_n;
  logic [CW-1:0] drop, drop_n;
  logic [CW-1:0] fifo_count, fifo_count_n;
  logic [AW-1:0] rq_wr, rq_rd, fq_wr, fq_rd;
  logic [63:0]   rq_mem   [FIFO_DEPTH];
  logic [63:0]   fq_pc    [FIFO_DEPTH];
  logic [31:0]   fq_instr [FIFO_DEPTH];
  logic          fire, pop, resp_keep, resp_drop;
  logic [CW:0]   occupancy;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + AW'(1);
  endfunction

  assign id_valid      = (fifo_count != '0);
  assign id_pc         = id_valid ? fq_pc[fq_rd]    : 64'h0;
  assign id_instr      = id_valid ? fq_instr[fq_rd] : 32'h0;
  assign imem_req_addr = pc;

  // A redirect overrides the decode handshake and discards any same-cycle response.
  assign pop       = id_valid && id_ready && !redirect_valid && !rst;
  assign resp_keep = imem_resp_valid && (drop == '0) && !redirect_valid && !rst;
  assign resp_drop = imem_resp_valid && (drop != '0) && !redirect_valid && !rst;

  // An entry leaving to decode this cycle frees its slot for a request this cycle,
  // which is what sustains one instruction per cycle with a 2-entry buffer.
  assign occupancy = {1'b0, outstanding} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};

  assign imem_req_valid = !rst && !redirect_valid && (state == RUN) && (occupancy < DEPTH_C);
  assign fire           = imem_req_valid && imem_req_ready;

  always_comb begin
    state_n       = state;
    drop_n        = drop;
    outstanding_n = outstanding + CW'(fire) - CW'(imem_resp_valid);
    fifo_count_n  = fifo_count + CW'(resp_keep) - CW'(pop);
    if (redirect_valid) begin
      fifo_count_n = '0;
      drop_n       = outstanding_n;
      state_n      = (outstanding_n != '0) ? FLUSH : RUN;
    end else begin
      drop_n = drop - CW'(resp_drop);
      if (state == FLUSH && drop_n == '0) begin
        state_n = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      fifo_count  <= '0;
      rq_wr       <= '0;
      rq_rd       <= '0;
      fq_wr       <= '0;
      fq_rd       <= '0;
    end else begin
      state       <= state_n;
      outstanding <= outstanding_n;
      drop        <= drop_n;
      fifo_count  <= fifo_count_n;
      if (redirect_valid) begin
        pc    <= redirect_pc & ~64'd3;
        rq_wr <= '0;
        rq_rd <= '0;
        fq_wr <= '0;
        fq_rd <= '0;
      end else begin
        if (fire) begin
          pc    <= pc + 64'd4;
          rq_wr <= ptr_inc(rq_wr);
        end
        if (resp_keep) begin
          rq_rd <= ptr_inc(rq_rd);
          fq_wr <= ptr_inc(fq_wr);
        end
        if (pop) begin
          fq_rd <= ptr_inc(fq_rd);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      rq_mem[rq_wr] <= pc;
    end
    if (resp_keep) begin
      fq_pc[fq_wr]    <= rq_mem[rq_rd];
      fq_instr[fq_wr] <= imem_resp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_resp_valid && outstanding == '0));
      assert (!(resp_keep && fifo_count == FULL_C && !pop));
    end
  end

endmodule
